apb_req_arbiter: RTL and testbench
==================================

// Module: apb_req_arbiter
// PURPOSE
// - Round-robin arbiter and APB master sharing one APB slave port between NREQ
//   requesters (CPU model, DMA, test sequencer).
// - Accepts one read/write request per requester handshake.
// - Sequences the APB SETUP/ACCESS phases, honours pready wait states and
//   returns read data/status to the winning requester.
// - Sits between the requester fabric and the apb_slave memory.
// PARAMETERS
// - NREQ            2    number of requesters (2..8)
// - ADDR_W          32   paddr / req_addr width
// - DATA_W          32   pwdata / prdata width
// - TIMEOUT_CYCLES  16   wait-state limit in ACCESS (used only with APB_ARB_TIMEOUT_EN)
// PORTS
// - pclk       in   1              APB clock, all logic posedge
// - prst       in   1              reset, asynchronous, active-low
// - req_valid  in   NREQ           request pending, one bit per requester
// - req_write  in   NREQ           1=write, 0=read
// - req_addr   in   NREQ*ADDR_W    packed addresses, requester i at [i*ADDR_W +: ADDR_W]
// - req_wdata  in   NREQ*DATA_W    packed write data, same packing
// - req_ready  out  NREQ           one-hot grant; request i accepted at edge where valid&ready
// - rsp_valid  out  NREQ           one-hot, 1-cycle completion pulse to accepted requester
// - rsp_rdata  out  DATA_W         read data, valid with rsp_valid (0 for writes)
// - rsp_err    out  1              1 = transfer timed out, valid with rsp_valid
// - psel       out  1              APB select
// - penable    out  1              APB enable
// - pwrite     out  1              APB direction
// - paddr      out  ADDR_W         APB address
// - pwdata     out  DATA_W         APB write data
// - prdata     in   DATA_W         APB read data
// - pready     in   1              APB ready; sampled only in ACCESS
// BEHAVIOUR
// - Reset (prst low, async): all outputs 0, state IDLE, RR pointer 0; in-flight transfer dropped, no rsp.
// - FSM states: IDLE -> SETUP -> ACCESS -> IDLE.
// - IDLE:
//   - req_ready is combinational; it is high only for the winner = first req_valid bit at or after
//     the RR pointer (wrapping NREQ-1 -> 0).
//   - On handshake: latch write/addr/wdata into paddr/pwrite/pwdata, record the winner index,
//     set pointer = winner+1 mod NREQ, go to SETUP.
//   - No valid: remain in IDLE, APB outputs held, psel=0.
// - SETUP (1 cycle): psel=1, penable=0; next ACCESS.
// - ACCESS: psel=1, penable=1, paddr/pwrite/pwdata stable.
//   - pready=0: stay in ACCESS (wait state).
//   - pready=1: go to IDLE; next cycle rsp_valid[winner]=1.
//     - Read: rsp_rdata = prdata sampled at that edge.
//     - Write: rsp_rdata = 0.
//     - rsp_err = 0.
// - Exit to IDLE: psel=0 and penable=0 in the same edge.
// - rsp_valid pulse overlaps the IDLE cycle; a new grant in that same cycle is legal.
// - Minimum 3 cycles per transfer: grant to psel is 1 cycle; SETUP to completion is >= 2 cycles.
// - Requesters hold req fields stable while valid&&!ready; a deasserted valid withdraws the request.
// - At most one outstanding transfer; req_ready is all-zero outside IDLE.
// - Simultaneous valid from all requesters: strict rotation, no requester starved more than NREQ-1 grants.
// - Address/data are passed through unmodified; no alignment checks (slave handles paddr%4).
// CONFIGURATION
// - APB_ARB_TIMEOUT_EN defined:
//   - 8-bit counter clears on SETUP and increments each ACCESS cycle with pready=0.
//   - When the count reaches TIMEOUT_CYCLES, the transfer is aborted: psel=penable=0, go to IDLE,
//     then rsp_valid with rsp_err=1 and rsp_rdata=0.
//   - pready=1 on the limit cycle completes normally with rsp_err=0.
// - APB_ARB_TIMEOUT_EN undefined:
//   - No counter; ACCESS waits indefinitely.
//   - rsp_err tied 0; TIMEOUT_CYCLES unused.
// TESTING
// - Req0 write addr=0x10 wdata=0xA5A5_1234, pready=1:
//   - psel rises 1 cycle after grant; penable the next cycle.
//   - rsp_valid[0] 1 cycle after ACCESS.
// - Req1 read addr=0x10 after the write above, slave returns 0xA5A5_1234:
//   - rsp_valid[1]=1, rsp_rdata=0xA5A5_1234, rsp_err=0.
// - Both valid continuously for 4 transfers, pointer=0:
//   - grant order 0,1,0,1.
//   - pointer wrap verified with NREQ=3: order 0,1,2,0.
// - pready low for 3 ACCESS cycles:
//   - psel/penable/paddr/pwdata stable for 4 ACCESS cycles.
//   - a single rsp_valid pulse.
// - prst low during ACCESS of a read:
//   - psel, penable, rsp_valid drop to 0 immediately.
//   - after release the first grant goes to req0; no stale response.
// - APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, pready held 0:
//   - abort after 4 ACCESS cycles, rsp_err=1, rsp_rdata=0.
//   - next request proceeds normally.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - round-robin arbiter and APB master sharing one slave port between NREQ requesters
// Optional feature macro: APB_ARB_TIMEOUT_EN (ACCESS wait-state timeout with error response)
module apb_req_arbiter #(
    parameter int NREQ           = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     pclk,
    input  logic                     prst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     psel,
    output logic                     penable,
    output logic                     pwrite,
    output logic [ADDR_W-1:0]        paddr,
    output logic [DATA_W-1:0]        pwdata,
    input  logic [DATA_W-1:0]        prdata,
    input  logic                     pready
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t           state, state_n;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W:0]   cand;
    logic             win_found;
    logic             done_ok;
    logic             done_abort;

    // Winner: first valid requester at or after the pointer, wrapping once.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NREQ))
                cand = cand - (PTR_W+1)'(NREQ);
            if (!win_found && req_valid[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
    end

    assign req_ready = (prst && state == IDLE && win_found) ? (NREQ'(1) << win_idx) : '0;
    assign done_ok   = (state == ACCESS) && pready;

`ifdef APB_ARB_TIMEOUT_EN
    logic [7:0] acc_cnt;

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst)
            acc_cnt <= '0;
        else if (state == SETUP)
            acc_cnt <= '0;
        else if (state == ACCESS && !pready)
            acc_cnt <= acc_cnt + 8'd1;
    end

    // Abort on the cycle whose wait state would bring the count to the limit.
    assign done_abort = (state == ACCESS) && !pready && (acc_cnt + 8'd1 == 8'(TIMEOUT_CYCLES));
`else
    assign done_abort = 1'b0;
`endif

    always_comb begin
        state_n = state;
        psel    = 1'b0;
        penable = 1'b0;
        case (state)
            IDLE: begin
                if (win_found)
                    state_n = SETUP;
            end
            SETUP: begin
                psel    = 1'b1;
                state_n = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (done_ok || done_abort)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            rsp_valid <= '0;
            if (state == IDLE && win_found) begin
                paddr  <= req_addr[win_idx*ADDR_W +: ADDR_W];
                pwdata <= req_wdata[win_idx*DATA_W +: DATA_W];
                pwrite <= req_write[win_idx];
                owner  <= win_idx;
                ptr    <= (win_idx == PTR_W'(NREQ-1)) ? '0 : win_idx + 1'b1;
            end
            if (done_ok) begin
                rsp_valid <= NREQ'(1) << owner;
                rsp_rdata <= pwrite ? '0 : prdata;
                rsp_err   <= 1'b0;
            end else if (done_abort) begin
                rsp_valid <= NREQ'(1) << owner;
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - directed scoreboard bench for apb_req_arbiter (NREQ=3, TIMEOUT_CYCLES=4)
module tb_apb_req_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TO   = 4;

    logic              pclk = 1'b0;
    logic              prst;
    logic [NREQ-1:0]   req_valid, req_write, req_ready, rsp_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [DW-1:0]     rsp_rdata, pwdata, prdata;
    logic [AW-1:0]     paddr;
    logic              rsp_err, psel, penable, pwrite, pready;

    always #5 pclk = ~pclk;

    apb_req_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .pclk(pclk), .prst(prst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready)
    );

    typedef struct {int idx; logic w; logic [31:0] a; logic [31:0] d;} req_t;
    typedef struct {int idx; logic [31:0] rdata; logic err;} exp_t;

    req_t pend[$];
    exp_t exp_q[$];
    int   grant_q[$];
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] slv_mem   [logic [31:0]];

    int checks = 0, errors = 0;
    int cyc = 0, last_hs_cyc = 0, acc_n = 0, acc_len = 0, wait_cfg = 0, rsp_cnt = 0, rdy_viol = 0;
    logic abort_mode = 1'b0;
    logic [31:0] last_rdata;
    logic            psel_log [0:2047];
    logic            pen_log  [0:2047];
    logic [NREQ-1:0] rsp_log  [0:2047];
    logic [31:0]     addr_log [0:2047];
    logic [31:0]     wd_log   [0:2047];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int i);
        return NREQ'(1) << i;
    endfunction

    task automatic update_drives();
        for (int i = 0; i < NREQ; i++) begin
            logic found;
            found = 1'b0;
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i*AW +: AW]  = '0;
            req_wdata[i*DW +: DW] = '0;
            for (int j = 0; j < pend.size(); j++) begin
                if (!found && pend[j].idx == i) begin
                    found = 1'b1;
                    req_valid[i] = 1'b1;
                    req_write[i] = pend[j].w;
                    req_addr[i*AW +: AW]  = pend[j].a;
                    req_wdata[i*DW +: DW] = pend[j].d;
                end
            end
        end
    endtask

    task automatic add_req(input int idx, input logic w, input logic [31:0] a, input logic [31:0] d);
        req_t r;
        r.idx = idx; r.w = w; r.a = a; r.d = d;
        pend.push_back(r);
        update_drives();
    endtask

    // One clock: sample at negedge (slave model, handshake, scoreboard), then update drives after posedge.
    task automatic tick();
        logic [NREQ-1:0] hs;
        req_t r;
        exp_t e;
        int   g;
        logic found;
        @(negedge pclk);
        cyc++;
        psel_log[cyc] = psel; pen_log[cyc] = penable; rsp_log[cyc] = rsp_valid;
        addr_log[cyc] = paddr; wd_log[cyc] = pwdata;
        if (psel && req_ready != '0) rdy_viol++;
        if (psel && penable) begin
            acc_n++;
            acc_len = acc_n;
            pready  = (acc_n > wait_cfg);
            prdata  = 32'hDEAD_BEEF;
            if (pready) begin
                if (pwrite) slv_mem[paddr] = pwdata;
                else prdata = slv_mem.exists(paddr) ? slv_mem[paddr] : 32'h0;
            end
        end else begin
            acc_n  = 0;
            pready = 1'b0;
            prdata = 32'hDEAD_BEEF;
        end
        hs = req_valid & req_ready;
        if (hs != '0) begin
            check("hs_onehot", 64'($countones(hs)), 64'd1);
            g = 0;
            for (int i = 0; i < NREQ; i++) if (hs[i]) g = i;
            grant_q.push_back(g);
            last_hs_cyc = cyc;
            found = 1'b0;
            r = '{idx: 0, w: 1'b0, a: 32'h0, d: 32'h0};
            for (int j = 0; j < pend.size(); j++) begin
                if (!found && pend[j].idx == g) begin
                    found = 1'b1;
                    r = pend[j];
                    pend.delete(j);
                end
            end
            e.idx = g;
            e.err = abort_mode;
            if (abort_mode) e.rdata = 32'h0;
            else if (r.w) begin
                model_mem[r.a] = r.d;
                e.rdata = 32'h0;
            end else e.rdata = model_mem.exists(r.a) ? model_mem[r.a] : 32'h0;
            exp_q.push_back(e);
        end
        if (rsp_valid != '0) begin
            rsp_cnt++;
            last_rdata = rsp_rdata;
            if (exp_q.size() == 0) check("rsp_unexpected", 64'(rsp_valid), 64'd0);
            else begin
                e = exp_q.pop_front();
                check("rsp_valid", 64'(rsp_valid), 64'(onehot(e.idx)));
                check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                check("rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
        @(posedge pclk);
        #1;
        update_drives();
    endtask

    task automatic run_all(input int max);
        int n;
        n = 0;
        while ((pend.size() != 0 || exp_q.size() != 0) && n < max) begin
            tick();
            n++;
        end
        check("drain_bound", 64'(pend.size() + exp_q.size()), 64'd0);
    endtask

    initial begin
        int g, n, s0, unstable, n_acc, n_rsp, first;
        int ord4[4];
        int ord6[6];
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        pready = 1'b0; prdata = '0; last_rdata = '0;
        prst = 1'b0;
        repeat (2) @(posedge pclk);
        req_valid = '1;
        @(negedge pclk);
        check("rst_psel", 64'(psel), 64'd0);
        check("rst_penable", 64'(penable), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_paddr", 64'(paddr), 64'd0);
        check("rst_pwdata", 64'(pwdata), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        req_valid = '0;
        @(posedge pclk);
        #1 prst = 1'b1;

        // Write from req0, zero wait states: latency profile
        grant_q.delete();
        add_req(0, 1'b1, 32'h10, 32'hA5A5_1234);
        run_all(20);
        g = last_hs_cyc;
        check("t1_grant", 64'(grant_q.size() > 0 ? grant_q[0] : -1), 64'd0);
        check("t1_psel_grant_cyc", 64'(psel_log[g]), 64'd0);
        check("t1_psel_rise", 64'(psel_log[g+1]), 64'd1);
        check("t1_pen_setup", 64'(pen_log[g+1]), 64'd0);
        check("t1_pen_access", 64'(pen_log[g+2]), 64'd1);
        check("t1_rsp_cycle", 64'(rsp_log[g+3]), 64'b001);
        check("t1_psel_drop", 64'(psel_log[g+3]), 64'd0);

        // Read back from req1
        add_req(1, 1'b0, 32'h10, 32'h0);
        run_all(20);
        check("t2_rdata", 64'(last_rdata), 64'hA5A5_1234);

        // Three wait states on req2 write
        wait_cfg = 3;
        s0 = cyc;
        add_req(2, 1'b1, 32'h20, 32'h1234_5678);
        run_all(30);
        wait_cfg = 0;
        unstable = 0; n_acc = 0; n_rsp = 0; first = 0;
        for (int c = s0 + 1; c <= cyc; c++) begin
            if (pen_log[c]) begin
                if (n_acc == 0) first = c;
                else if (addr_log[c] !== addr_log[first] || wd_log[c] !== wd_log[first] || !psel_log[c])
                    unstable++;
                n_acc++;
            end
            if (rsp_log[c] != '0) n_rsp++;
        end
        check("t3_access_cycles", 64'(n_acc), 64'd4);
        check("t3_stable", 64'(unstable), 64'd0);
        check("t3_paddr", 64'(addr_log[first]), 64'h20);
        check("t3_rsp_pulses", 64'(n_rsp), 64'd1);

        // Reset while req0 read is in ACCESS
        wait_cfg = 5;
        add_req(0, 1'b0, 32'h10, 32'h0);
        n = 0;
        while (!(psel && penable) && n < 20) begin
            tick();
            n++;
        end
        check("t4_reach_access", 64'(psel && penable), 64'd1);
        #2 prst = 1'b0;
        #1;
        check("t4_rst_psel", 64'(psel), 64'd0);
        check("t4_rst_penable", 64'(penable), 64'd0);
        check("t4_rst_rsp", 64'(rsp_valid), 64'd0);
        pend.delete();
        exp_q.delete();
        update_drives();
        wait_cfg = 0;
        rsp_cnt = 0;
        repeat (2) tick();
        prst = 1'b1;

        // Two requesters continuously valid after reset: 0,1,0,1
        grant_q.delete();
        add_req(0, 1'b1, 32'h30, 32'h1111_0000);
        add_req(0, 1'b0, 32'h30, 32'h0);
        add_req(1, 1'b1, 32'h34, 32'h2222_0001);
        add_req(1, 1'b0, 32'h34, 32'h0);
        run_all(60);
        ord4 = '{0, 1, 0, 1};
        check("t5_grants", 64'(grant_q.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t5_order%0d", i), 64'(grant_q.size() > i ? grant_q[i] : -1), 64'(ord4[i]));
        check("t5_rsp_count", 64'(rsp_cnt), 64'd4);

        // Move pointer back to 0, then all three valid: 0,1,2,0,1,2
        add_req(2, 1'b0, 32'h20, 32'h0);
        run_all(20);
        check("t6_prev_rdata", 64'(last_rdata), 64'h1234_5678);
        grant_q.delete();
        for (int i = 0; i < NREQ; i++) begin
            add_req(i, 1'b1, 32'h100 + 32'(i*4), 32'hBEE0_0000 + 32'(i));
            add_req(i, 1'b0, 32'h100 + 32'(i*4), 32'h0);
        end
        run_all(80);
        ord6 = '{0, 1, 2, 0, 1, 2};
        for (int i = 0; i < 6; i++)
            check($sformatf("t6_order%0d", i), 64'(grant_q.size() > i ? grant_q[i] : -1), 64'(ord6[i]));

`ifdef APB_ARB_TIMEOUT_EN
        // Slave never ready: abort after TO access cycles with error
        wait_cfg = 1000;
        abort_mode = 1'b1;
        add_req(1, 1'b1, 32'h40, 32'hCAFE_F00D);
        run_all(40);
        abort_mode = 1'b0;
        wait_cfg = 0;
        check("t7_abort_len", 64'(acc_len), 64'(TO));
        add_req(0, 1'b0, 32'h40, 32'h0);
        run_all(20);
        check("t7_next_rdata", 64'(last_rdata), 64'h0);
`else
        // Long wait without timeout: transfer completes normally
        wait_cfg = 20;
        add_req(1, 1'b1, 32'h40, 32'hCAFE_F00D);
        run_all(60);
        wait_cfg = 0;
        check("t7_wait_len", 64'(acc_len), 64'd21);
        add_req(0, 1'b0, 32'h40, 32'h0);
        run_all(20);
        check("t7_next_rdata", 64'(last_rdata), 64'hCAFE_F00D);
`endif
        check("ready_outside_idle", 64'(rdy_viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
